// File: rtl/pc_redirect_ctrl_pkg.sv
// pc_redirect_ctrl_pkg
// Purpose : shared definitions for the fetch-PC redirect controller slice.
//           Holds the datapath width, the default reset fetch index and the
//           controller state encodings.
// Ports   : none (package).
// Config  : PC_REDIRECT_STATS_EN (used by pc_redirect_ctrl) adds redirect
//           statistics counters; nothing in this package depends on it.
package pc_redirect_ctrl_pkg;

  // Architectural width of the fetch word index.
  localparam int XLEN = 32;

  // Word index fetched first after reset unless the instance overrides it.
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'd0;

  // Controller states, kept as plain 2-bit constants so older tooling in the
  // pipeline can still compare against them directly.
  typedef logic [1:0] state_t;
  localparam state_t STATE_BOOT   = 2'd0;
  localparam state_t STATE_RUN    = 2'd1;
  localparam state_t STATE_SQUASH = 2'd2;

endpackage

// File: rtl/squash_timer.sv
// squash_timer
// Purpose : loadable down-counter that times the fetch squash window after a
//           branch redirect. It stops at zero and reports zero through a flag.
// Ports   : clk       - rising-edge clock
//           reset     - synchronous, active-high; clears the count to 0
//           load      - load loadValue this cycle (wins over decrement)
//           loadValue - value to load
//           dec       - decrement by one when non-zero
//           zero      - count is currently zero
// Config  : no configuration macros.
module squash_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // The count sits at zero when idle. A load always takes priority so a new
  // window can start on the same edge the previous one would have expired.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Zero flag is decoded from the register so the controller sees it with no
  // path back to any primary input.
  assign zero = (count == '0);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
// Purpose : owns the architectural fetch PC. Advances it each cycle, holds it
//           on a hazard stall, and on a taken EX-stage branch loads the target,
//           pulses the IF/ID and ID/EX flushes for one cycle and keeps fetch
//           invalid for SQUASH_CYCLES cycles before resuming at the target.
// Ports   : clk           - rising-edge pipeline clock
//           reset         - synchronous, active-high
//           br_success    - branch taken this cycle (from EX)
//           br_target     - redirect target word index
//           stall         - hazard unit holds the fetch PC
//           pc            - registered fetch word index
//           fetch_valid   - pc is a live fetch
//           flush_if_id   - one-cycle IF/ID clear
//           flush_id_ex   - one-cycle ID/EX clear
//           redirect_busy - high while squashing
//           taken_count   - accepted redirects (PC_REDIRECT_STATS_EN only)
//           squash_count  - cycles spent squashing (PC_REDIRECT_STATS_EN only)
// Config  : define PC_REDIRECT_STATS_EN to add the saturating statistics
//           counters; without it the ports and counters do not exist.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC      = DEFAULT_RESET_PC,
  parameter int              SQUASH_CYCLES = 2,
  parameter int              CNT_W         = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            br_success,
  input  logic [XLEN-1:0] br_target,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            redirect_busy
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0]     taken_count,
  output logic [31:0]     squash_count
`endif
);

  // The timer counts down to zero and the exit happens on the zero cycle, so
  // loading N-1 yields exactly N invalid-fetch cycles.
  localparam logic [CNT_W-1:0] SQUASH_LOAD = CNT_W'(SQUASH_CYCLES - 1);

  state_t state;
  logic   takeRedirect;
  logic   squashDone;

  // A redirect is only accepted while running; BOOT and SQUASH ignore EX.
  assign takeRedirect = (state == STATE_RUN) && br_success;

  squash_timer #(
    .CNT_W (CNT_W)
  ) u_squash_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (takeRedirect),
    .loadValue (SQUASH_LOAD),
    .dec       (state == STATE_SQUASH),
    .zero      (squashDone)
  );

  // Main sequencer. Flushes default low every cycle so they can only ever be
  // a single-cycle pulse on the RUN->SQUASH edge. Redirect beats stall, stall
  // beats increment; pc+1 wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= STATE_BOOT;
      pc            <= RESET_PC;
      fetch_valid   <= 1'b0;
      flush_if_id   <= 1'b0;
      flush_id_ex   <= 1'b0;
      redirect_busy <= 1'b0;
    end else begin
      flush_if_id <= 1'b0;
      flush_id_ex <= 1'b0;
      case (state)
        STATE_BOOT: begin
          state       <= STATE_RUN;
          fetch_valid <= 1'b1;
        end
        STATE_RUN: begin
          if (br_success) begin
            pc            <= br_target;
            flush_if_id   <= 1'b1;
            flush_id_ex   <= 1'b1;
            fetch_valid   <= 1'b0;
            redirect_busy <= 1'b1;
            state         <= STATE_SQUASH;
          end else if (!stall) begin
            pc <= pc + 1'b1;
          end
        end
        STATE_SQUASH: begin
          if (squashDone) begin
            state         <= STATE_RUN;
            fetch_valid   <= 1'b1;
            redirect_busy <= 1'b0;
          end
        end
        default: begin
          state         <= STATE_BOOT;
          fetch_valid   <= 1'b0;
          redirect_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  // Statistics: both counters stick at all-ones rather than wrapping so a
  // long run never reports a misleadingly small number.
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_count  <= '0;
      squash_count <= '0;
    end else begin
      if (takeRedirect && (taken_count != 32'hFFFF_FFFF)) begin
        taken_count <= taken_count + 1'b1;
      end
      if ((state == STATE_SQUASH) && (squash_count != 32'hFFFF_FFFF)) begin
        squash_count <= squash_count + 1'b1;
      end
    end
  end
`else
  // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl
// Purpose : directed scoreboard bench for pc_redirect_ctrl with default
//           parameters (RESET_PC=0, SQUASH_CYCLES=2). Each stimulus cycle
//           pushes the hand-computed outputs expected after the next edge; an
//           independent monitor pops and compares them one step after the edge.
// Ports   : none (top-level bench).
// Config  : honours PC_REDIRECT_STATS_EN to connect and check the counters.
`timescale 1ns/1ps
module tb_pc_redirect_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        flush;
    logic        busy;
    logic        statsChk;
    logic [31:0] taken;
    logic [31:0] squash;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        br_success;
  logic [31:0] br_target;
  logic        stall;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        redirect_busy;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] taken_count;
  logic [31:0] squash_count;
`endif

  exp_t expQ[$];
  int   checksTotal;
  int   checksPassed;

  pc_redirect_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .br_success    (br_success),
    .br_target     (br_target),
    .stall         (stall),
    .pc            (pc),
    .fetch_valid   (fetch_valid),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .redirect_busy (redirect_busy)
`ifdef PC_REDIRECT_STATS_EN
    ,
    .taken_count   (taken_count),
    .squash_count  (squash_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed field against its expected value and tally it.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue what the outputs
  // must look like after the following rising edge.
  task automatic applyStimulus(input logic r, input logic br, input logic [31:0] tgt,
                               input logic st, input logic [31:0] ePc, input logic eFv,
                               input logic eFl, input logic eBusy,
                               input logic sChk = 1'b0, input logic [31:0] eTaken = 0,
                               input logic [31:0] eSquash = 0);
    exp_t e;
    @(negedge clk);
    reset      = r;
    br_success = br;
    br_target  = tgt;
    stall      = st;
    e.pc = ePc; e.fv = eFv; e.flush = eFl; e.busy = eBusy;
    e.statsChk = sChk; e.taken = eTaken; e.squash = eSquash;
    expQ.push_back(e);
  endtask

  // Monitor: one step after every rising edge, consume the expectation queued
  // for that edge and compare every output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pc", pc, e.pc);
        checkOutput("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
        checkOutput("flush_if_id", {31'd0, flush_if_id}, {31'd0, e.flush});
        checkOutput("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, e.flush});
        checkOutput("redirect_busy", {31'd0, redirect_busy}, {31'd0, e.busy});
`ifdef PC_REDIRECT_STATS_EN
        if (e.statsChk) begin
          checkOutput("taken_count", taken_count, e.taken);
          checkOutput("squash_count", squash_count, e.squash);
        end
`endif
      end
    end
  end

  initial begin
    int waitCycles;
    checksTotal  = 0;
    checksPassed = 0;
    reset      = 1'b1;
    br_success = 1'b0;
    br_target  = 32'd0;
    stall      = 1'b0;

    //             rst br  target        st  pc            fv  fl  busy
    // Reset, then BOOT for one cycle, then sequential fetch from 0.
    applyStimulus(1, 0, 32'h0,        0, 32'h0,        0,  0,  0);
    applyStimulus(1, 0, 32'h0,        0, 32'h0,        0,  0,  0);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        1,  0,  0);
    applyStimulus(0, 0, 32'h0,        0, 32'h1,        1,  0,  0);
    applyStimulus(0, 0, 32'h0,        0, 32'h2,        1,  0,  0);
    applyStimulus(0, 0, 32'h0,        0, 32'h3,        1,  0,  0);
    applyStimulus(0, 0, 32'h0,        0, 32'h4,        1,  0,  0);
    applyStimulus(0, 0, 32'h0,        0, 32'h5,        1,  0,  0);
    // Redirect at pc=5 to 0x40: two invalid cycles, then 0x40, 0x41.
    applyStimulus(0, 1, 32'h40,       0, 32'h40,       0,  1,  1);
    applyStimulus(0, 0, 32'h0,        0, 32'h40,       0,  0,  1);
    applyStimulus(0, 0, 32'h0,        0, 32'h40,       1,  0,  0);
    applyStimulus(0, 0, 32'h0,        0, 32'h41,       1,  0,  0);
    // Redirect to 7, then stall three cycles at pc=7.
    applyStimulus(0, 1, 32'h7,        0, 32'h7,        0,  1,  1);
    applyStimulus(0, 0, 32'h0,        0, 32'h7,        0,  0,  1);
    applyStimulus(0, 0, 32'h0,        0, 32'h7,        1,  0,  0);
    applyStimulus(0, 0, 32'h0,        1, 32'h7,        1,  0,  0);
    applyStimulus(0, 0, 32'h0,        1, 32'h7,        1,  0,  0);
    applyStimulus(0, 0, 32'h0,        1, 32'h7,        1,  0,  0);
    applyStimulus(0, 0, 32'h0,        0, 32'h8,        1,  0,  0);
    // Stall plus branch: redirect wins. Branches during SQUASH are ignored.
    applyStimulus(0, 1, 32'h10,       1, 32'h10,       0,  1,  1);
    applyStimulus(0, 1, 32'h99,       0, 32'h10,       0,  0,  1);
    applyStimulus(0, 1, 32'h99,       1, 32'h10,       1,  0,  0);
    applyStimulus(0, 0, 32'h0,        0, 32'h11,       1,  0,  0);
    // Reset in the middle of a squash window.
    applyStimulus(0, 1, 32'h20,       0, 32'h20,       0,  1,  1);
    applyStimulus(1, 0, 32'h0,        0, 32'h0,        0,  0,  0);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        1,  0,  0);
    // Redirect to the top word index, then the increment wraps to 0.
    applyStimulus(0, 1, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0,  1,  1);
    applyStimulus(0, 0, 32'h0,        0, 32'hFFFFFFFF, 0,  0,  1);
    applyStimulus(0, 0, 32'h0,        0, 32'hFFFFFFFF, 1,  0,  0);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        1,  0,  0);
    // One redirect since the last reset: one taken, two squash cycles.
    applyStimulus(0, 0, 32'h0,        0, 32'h1,        1,  0,  0, 1, 32'd1, 32'd2);
    // Reset with a branch present, then BOOT ignores the branch.
    applyStimulus(1, 1, 32'h55,       0, 32'h0,        0,  0,  0, 1, 32'd0, 32'd0);
    applyStimulus(0, 1, 32'h55,       0, 32'h0,        1,  0,  0, 1, 32'd0, 32'd0);
    applyStimulus(0, 0, 32'h0,        0, 32'h1,        1,  0,  0);

    // Give the monitor a bounded number of cycles to drain the scoreboard.
    waitCycles = 0;
    while ((expQ.size() > 0) && (waitCycles < 20)) begin
      @(negedge clk);
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      checksTotal++;
      $display("[TB] FAIL drain: %0d entries left, want 0", expQ.size());
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
